pbs_ctrl: RTL and testbench
===========================

PBS_CTRL -- requirements
Module: pbs_ctrl

Interface
REQ-001 Parameter MAX_TURNS, default 20: full turns (player + AI attack) before the battle is declared a draw; legal range 1..31.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  begins a battle; acted on only in IDLE.
REQ-005 move_valid  input  1  player move offered on the datapath move lines.
REQ-006 move_ready  output  1  controller accepts a move; high only in WAIT_MOVE.
REQ-007 p_hp, ai_hp  input  4 each  current HP from the datapath.
REQ-008 dmg, accu  input  4 each  damage and accuracy of the currently selected move.
REQ-009 acc_rng  input  4  random value used for the hit check.
REQ-010 actr  output  1  trainer select: 0 = player move, 1 = AI move.
REQ-011 target  output  1  damage target: 0 = player, 1 = AI.
REQ-012 stop  output  1  freezes the random sources while a move is sampled.
REQ-013 load_ai_hp, app_ai_dmg, app_pl_dmg  output  1 each  single-cycle datapath strobes.
REQ-014 winner  output  2  result: 00 none, 01 player, 10 AI, 11 draw.
REQ-015 done  output  1  battle over; high in GAME_OVER.
REQ-016 turn_cnt  output  5  count of completed full turns.

Function
REQ-017 FSM states: IDLE, WAIT_MOVE, PL_SEL, PL_EVAL, PL_APPLY, AI_SEL, AI_EVAL, AI_APPLY, GAME_OVER.
REQ-018 All outputs are Moore outputs, decoded from the state register and registered counters only.
REQ-019 IDLE: start=1 moves the FSM to WAIT_MOVE next cycle.
REQ-020 WAIT_MOVE: a move is accepted in the cycle where move_valid and move_ready are both 1; the FSM then moves to PL_SEL.
REQ-021 PL_SEL: actr=0, target=1, load_ai_hp=1 for 1 cycle, then PL_EVAL.
- The datapath registers the trainer select, so dmg/accu are valid in the EVAL state that follows, not in SEL.
REQ-022 PL_EVAL, on a hit:
- dmg >= ai_hp: winner=01, then GAME_OVER.
- otherwise: PL_APPLY.
REQ-023 PL_EVAL, on a miss: skip directly to AI_SEL.
REQ-024 PL_APPLY: app_ai_dmg=1 for 1 cycle, then AI_SEL.
REQ-025 AI_SEL: actr=1, target=0, stop=1 for 1 cycle, then AI_EVAL.
REQ-026 AI_EVAL: stop=1; same hit/KO rules as PL_EVAL, compared against p_hp.
- KO: winner=10, then GAME_OVER.
- Miss: skip to the turn-end step.
REQ-027 AI_APPLY: app_pl_dmg=1 for 1 cycle.
REQ-028 Turn end (after AI_APPLY or an AI miss):
- turn_cnt increments.
- If the new value equals MAX_TURNS: winner=11, then GAME_OVER.
- Else: WAIT_MOVE.
REQ-029 A damage strobe is never issued when dmg >= target HP, so 4-bit HP never wraps below zero.
REQ-030 At most one of load_ai_hp, app_ai_dmg, app_pl_dmg is high in any cycle.
REQ-031 GAME_OVER is sticky until rst:
- done=1 and winner is held.
- start and move_valid are ignored.
REQ-032 move_valid outside WAIT_MOVE and start outside IDLE have no effect.
REQ-033 turn_cnt is cleared on the IDLE->WAIT_MOVE transition.

Reset
REQ-034 While rst=0, independent of clk:
- State = IDLE.
- actr, target, stop, all strobes, done, move_ready = 0.
- winner = 00, turn_cnt = 0.
REQ-035 Reset asserted mid-battle (any state) returns to IDLE; an in-flight strobe is dropped.

Configuration
REQ-036 Macro PBS_MISS_EN selects the hit check in the EVAL states:
- Defined: an attack hits iff accu >= acc_rng (unsigned).
- Undefined: every attack hits, and acc_rng is unused.

Structure
REQ-037 Shared package pbs_pkg holds:
- The state enum.
- Winner codes WIN_NONE, WIN_PL, WIN_AI, WIN_DRAW.
- The actr and target encoding constants.
REQ-038 One sub-module, pbs_turn_cnt: 5-bit counter with clear and increment, plus a terminal-count flag compared against MAX_TURNS.

Verification
REQ-039 Basic turn:
- Stimulus: reset; start; move accepted; dmg=3, accu=15, ai_hp=15, then AI dmg=2, p_hp=15.
- Response: load_ai_hp, app_ai_dmg, app_pl_dmg each pulse once in order; turn_cnt=1; back in WAIT_MOVE.
REQ-040 Player KO:
- Stimulus: ai_hp=4, dmg=4 in PL_EVAL.
- Response: no app_ai_dmg; winner=01; done=1; the AI phase never entered.
REQ-041 Draw:
- Stimulus: MAX_TURNS=2, nonlethal dmg=1 on both sides.
- Response: after 2 full turns, winner=11 and turn_cnt=2.
REQ-042 Miss (PBS_MISS_EN defined):
- Stimulus: accu=5, acc_rng=9 on the player attack.
- Response: no app_ai_dmg; FSM goes to AI_SEL.
- Same stimulus with the macro undefined: app_ai_dmg pulses.
REQ-043 Reset mid-operation:
- Stimulus: rst=0 asserted in PL_APPLY.
- Response: outputs zero immediately (asynchronously); IDLE after release; start required to resume.
REQ-044 Handshake:
- Stimulus: move_valid held high during the AI phase.
- Response: no acceptance until WAIT_MOVE; accepted exactly once when move_ready is 1.

Source files
------------

// File: rtl/pbs_pkg.sv
// Shared types and encodings for the battle controller (pbs_ctrl and pbs_turn_cnt).
package pbs_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_MOVE,
        ST_PL_SEL,
        ST_PL_EVAL,
        ST_PL_APPLY,
        ST_AI_SEL,
        ST_AI_EVAL,
        ST_AI_APPLY,
        ST_GAME_OVER
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_PL   = 2'b01;
    localparam logic [1:0] WIN_AI   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam logic ACTR_PL = 1'b0;
    localparam logic ACTR_AI = 1'b1;

    localparam logic TGT_PL = 1'b0;
    localparam logic TGT_AI = 1'b1;

endpackage

// File: rtl/pbs_turn_cnt.sv
// Full-turn counter for the battle controller: clear, increment and a flag
// that is high when the next increment will reach MAX_TURNS.
module pbs_turn_cnt #(
    parameter int unsigned MAX_TURNS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [4:0] cnt,
    output logic       last_turn
);

    localparam logic [4:0] MAX_CNT = 5'(MAX_TURNS);

    logic [4:0] cnt_q;
    logic [4:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign last_turn = ((cnt_q + 5'd1) == MAX_CNT);

endmodule

// File: rtl/pbs_ctrl.sv
// Turn-based battle controller: sequences player and AI attacks against the HP datapath.
// Optional macro PBS_MISS_EN enables the accuracy hit check (otherwise every attack hits).
module pbs_ctrl
    import pbs_pkg::*;
#(
    parameter int unsigned MAX_TURNS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       move_valid,
    output logic       move_ready,
    input  logic [3:0] p_hp,
    input  logic [3:0] ai_hp,
    input  logic [3:0] dmg,
    input  logic [3:0] accu,
    input  logic [3:0] acc_rng,
    output logic       actr,
    output logic       target,
    output logic       stop,
    output logic       load_ai_hp,
    output logic       app_ai_dmg,
    output logic       app_pl_dmg,
    output logic [1:0] winner,
    output logic       done,
    output logic [4:0] turn_cnt
);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] winner_q;
    logic [1:0] winner_d;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       last_turn;
    logic       turn_end;
    logic       hit;

`ifdef PBS_MISS_EN
    assign hit = (accu >= acc_rng);
`else
    logic unused_rng;
    assign hit        = 1'b1;
    assign unused_rng = ^{accu, acc_rng};
`endif

    pbs_turn_cnt #(
        .MAX_TURNS(MAX_TURNS)
    ) u_turn_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .cnt      (turn_cnt),
        .last_turn(last_turn)
    );

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        turn_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT_MOVE;
                    cnt_clr = 1'b1;
                end
            end
            ST_WAIT_MOVE: begin
                if (move_valid) begin
                    state_d = ST_PL_SEL;
                end
            end
            ST_PL_SEL:   state_d = ST_PL_EVAL;
            ST_PL_EVAL: begin
                if (!hit) begin
                    state_d = ST_AI_SEL;
                end else if (dmg >= ai_hp) begin
                    state_d  = ST_GAME_OVER;
                    winner_d = WIN_PL;
                end else begin
                    state_d = ST_PL_APPLY;
                end
            end
            ST_PL_APPLY: state_d = ST_AI_SEL;
            ST_AI_SEL:   state_d = ST_AI_EVAL;
            ST_AI_EVAL: begin
                if (!hit) begin
                    turn_end = 1'b1;
                end else if (dmg >= p_hp) begin
                    state_d  = ST_GAME_OVER;
                    winner_d = WIN_AI;
                end else begin
                    state_d = ST_AI_APPLY;
                end
            end
            ST_AI_APPLY:  turn_end = 1'b1;
            ST_GAME_OVER: state_d = ST_GAME_OVER;
            default:      state_d = ST_IDLE;
        endcase

        // A full turn closes here; the draw check looks at the post-increment count.
        if (turn_end) begin
            cnt_inc = 1'b1;
            if (last_turn) begin
                state_d  = ST_GAME_OVER;
                winner_d = WIN_DRAW;
            end else begin
                state_d = ST_WAIT_MOVE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            winner_q <= WIN_NONE;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
        end
    end

    assign move_ready = (state_q == ST_WAIT_MOVE);
    assign actr       = (state_q inside {ST_AI_SEL, ST_AI_EVAL, ST_AI_APPLY}) ? ACTR_AI : ACTR_PL;
    assign target     = (state_q inside {ST_PL_SEL, ST_PL_EVAL, ST_PL_APPLY}) ? TGT_AI : TGT_PL;
    assign stop       = (state_q inside {ST_AI_SEL, ST_AI_EVAL});
    assign load_ai_hp = (state_q == ST_PL_SEL);
    assign app_ai_dmg = (state_q == ST_PL_APPLY);
    assign app_pl_dmg = (state_q == ST_AI_APPLY);
    assign done       = (state_q == ST_GAME_OVER);
    assign winner     = winner_q;

endmodule

// File: tb/tb_pbs_ctrl.sv
// Self-checking bench for pbs_ctrl: directed sequences, a table of battles and
// randomized battles checked against a battle-level reference model.
module tb_pbs_ctrl;

    localparam int MT = 2;
`ifdef PBS_MISS_EN
    localparam bit MISS_EN = 1'b1;
`else
    localparam bit MISS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       move_valid = 1'b0;
    logic [3:0] p_hp = '0, ai_hp = '0, dmg = '0, accu = '0, acc_rng = '0;
    logic       move_ready, actr, target, stop, load_ai_hp, app_ai_dmg, app_pl_dmg, done;
    logic [1:0] winner;
    logic [4:0] turn_cnt;

    always #5 clk = ~clk;

    pbs_ctrl #(.MAX_TURNS(MT)) dut (
        .clk(clk), .rst(rst), .start(start), .move_valid(move_valid), .move_ready(move_ready),
        .p_hp(p_hp), .ai_hp(ai_hp), .dmg(dmg), .accu(accu), .acc_rng(acc_rng),
        .actr(actr), .target(target), .stop(stop), .load_ai_hp(load_ai_hp),
        .app_ai_dmg(app_ai_dmg), .app_pl_dmg(app_pl_dmg), .winner(winner), .done(done),
        .turn_cnt(turn_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Scenario: initial HP plus per-turn move parameters for both trainers.
    logic [3:0] sc_p, sc_a;
    logic [3:0] sc_pd[8], sc_ad[8], sc_pacc[8], sc_prng[8], sc_aacc[8], sc_arng[8];

    // Bench-side datapath and observations.
    logic [3:0] dp_p, dp_a;
    logic       sel;
    int         turn_idx;
    int         obs_seq[$];
    int         obs_accepts, obs_stop, obs_overlap, obs_selbad;
    logic       prev_stop;

    // Reference model results.
    int exp_seq[$];
    int m_win, m_turns, m_stop;

    typedef struct {
        logic [3:0] p, a, pd, ad;
        int win, turns, n_load, n_aid, n_pld, n_stop;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic string seq_str(input int q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%0d", q[i])};
        return s;
    endfunction

    task automatic check_seq(input string name, input int eq[$]);
        bit ok = (eq.size() == obs_seq.size());
        if (ok) foreach (eq[i]) if (eq[i] != obs_seq[i]) ok = 1'b0;
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: strobe order got '%s', expected '%s'", name, seq_str(obs_seq), seq_str(eq));
    endtask

    function automatic int count_code(input int c);
        int n = 0;
        foreach (obs_seq[i]) if (obs_seq[i] == c) n++;
        return n;
    endfunction

    function automatic int out_vec();
        return int'({actr, target, stop, load_ai_hp, app_ai_dmg, app_pl_dmg, done, move_ready, winner, turn_cnt});
    endfunction

    function automatic bit hits(input logic [3:0] a, input logic [3:0] r);
        return !MISS_EN || (a >= r);
    endfunction

    task automatic set_const(input logic [3:0] p, a, pd, ad, pacc, prng, aacc, arng);
        sc_p = p; sc_a = a;
        for (int i = 0; i < 8; i++) begin
            sc_pd[i] = pd; sc_ad[i] = ad; sc_pacc[i] = pacc; sc_prng[i] = prng;
            sc_aacc[i] = aacc; sc_arng[i] = arng;
        end
    endtask

    task automatic drive_dp();
        int t = (turn_idx > 7) ? 7 : turn_idx;
        p_hp  = dp_p;
        ai_hp = dp_a;
        if (sel) begin
            dmg = sc_ad[t]; accu = sc_aacc[t]; acc_rng = sc_arng[t];
        end else begin
            dmg = sc_pd[t]; accu = sc_pacc[t]; acc_rng = sc_prng[t];
        end
    endtask

    // One clock: observe the current Moore outputs, act as the datapath at the edge.
    task automatic tick();
        logic [3:0] np = dp_p, na = dp_a;
        logic       nsel = actr;
        if (load_ai_hp) begin
            obs_seq.push_back(1);
            if (actr != 1'b0 || target != 1'b1) obs_selbad++;
        end
        if (app_ai_dmg) begin obs_seq.push_back(2); na = dp_a - dmg; end
        if (app_pl_dmg) begin obs_seq.push_back(3); np = dp_p - dmg; end
        if (int'(load_ai_hp) + int'(app_ai_dmg) + int'(app_pl_dmg) > 1) obs_overlap++;
        if (stop) begin
            obs_stop++;
            if (!prev_stop && (actr != 1'b1 || target != 1'b0)) obs_selbad++;
        end
        prev_stop = stop;
        if (move_valid && move_ready) begin
            turn_idx = obs_accepts;
            obs_accepts++;
        end
        @(posedge clk); #1;
        dp_p = np; dp_a = na; sel = nsel;
        drive_dp();
    endtask

    task automatic begin_battle();
        rst = 1'b0; start = 1'b0; move_valid = 1'b0;
        dp_p = sc_p; dp_a = sc_a; sel = 1'b0; turn_idx = 0;
        obs_seq.delete();
        obs_accepts = 0; obs_stop = 0; obs_overlap = 0; obs_selbad = 0; prev_stop = 1'b0;
        drive_dp();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; move_valid = 1'b1;
    endtask

    // Run to GAME_OVER (bounded), then keep start/move_valid high to probe stickiness.
    task automatic run_to_end(input string name);
        for (int c = 0; c < 60 && !done; c++) tick();
        check({name, " reached done"}, int'(done), 1);
        for (int c = 0; c < 3; c++) tick();
    endtask

    task automatic check_common(input string name, input int win, turns, nacc, nstop);
        check({name, " done held"}, int'(done), 1);
        check({name, " winner"}, int'(winner), win);
        check({name, " turn_cnt"}, int'(turn_cnt), turns);
        check({name, " moves accepted"}, obs_accepts, nacc);
        check({name, " stop cycles"}, obs_stop, nstop);
        check({name, " strobe overlap"}, obs_overlap, 0);
        check({name, " select encoding"}, obs_selbad, 0);
        check({name, " move_ready in game over"}, int'(move_ready), 0);
        $display("battle %s: p=%0d ai=%0d winner=%0d turns=%0d strobes=%s", name, sc_p, sc_a,
                 winner, turn_cnt, seq_str(obs_seq));
    endtask

    task automatic model();
        logic [3:0] php = sc_p, ahp = sc_a;
        exp_seq.delete();
        m_win = 3; m_turns = MT; m_stop = 0;
        for (int t = 0; t < MT; t++) begin
            exp_seq.push_back(1);
            if (hits(sc_pacc[t], sc_prng[t])) begin
                if (sc_pd[t] >= ahp) begin m_win = 1; m_turns = t; return; end
                exp_seq.push_back(2);
                ahp = ahp - sc_pd[t];
            end
            m_stop += 2;
            if (hits(sc_aacc[t], sc_arng[t])) begin
                if (sc_ad[t] >= php) begin m_win = 2; m_turns = t; return; end
                exp_seq.push_back(3);
                php = php - sc_ad[t];
            end
        end
    endtask

    initial begin
        int q[$];
        int loads;
        string nm;

        tbl[0] = '{4'd15, 4'd15, 4'd3,  4'd2,  3, 2, 2, 2, 2, 4};
        tbl[1] = '{4'd15, 4'd4,  4'd4,  4'd2,  1, 0, 1, 0, 0, 0};
        tbl[2] = '{4'd2,  4'd15, 4'd1,  4'd2,  2, 0, 1, 1, 0, 2};
        tbl[3] = '{4'd15, 4'd5,  4'd3,  4'd1,  1, 1, 2, 1, 1, 2};
        tbl[4] = '{4'd1,  4'd1,  4'd0,  4'd0,  3, 2, 2, 2, 2, 4};
        tbl[5] = '{4'd15, 4'd15, 4'd1,  4'd15, 2, 0, 1, 1, 0, 2};
        tbl[6] = '{4'd14, 4'd15, 4'd14, 4'd13, 1, 1, 2, 1, 1, 2};
        tbl[7] = '{4'd15, 4'd15, 4'd15, 4'd1,  1, 0, 1, 0, 0, 0};

        // Reset state, with start and move_valid driven while held in reset.
        start = 1'b1; move_valid = 1'b1;
        #1;
        check("reset outputs async", out_vec(), 0);
        @(posedge clk); #1;
        check("reset outputs after edge", out_vec(), 0);

        // Basic turn: strobes in order, one turn counted, back to WAIT_MOVE.
        set_const(4'd15, 4'd15, 4'd3, 4'd2, 4'd15, 4'd0, 4'd15, 4'd0);
        begin_battle();
        for (int c = 0; c < 40; c++) begin
            tick();
            if (obs_accepts == 1 && move_ready) break;
        end
        q = {1, 2, 3};
        check_seq("basic turn", q);
        check("basic turn_cnt", int'(turn_cnt), 1);
        check("basic back in wait_move", int'(move_ready), 1);
        check("basic winner none", int'(winner), 0);
        check("basic stop cycles", obs_stop, 2);
        $display("basic turn: strobes=%s turn_cnt=%0d", seq_str(obs_seq), turn_cnt);

        // Player attack with accu below acc_rng.
        set_const(4'd15, 4'd15, 4'd3, 4'd2, 4'd5, 4'd9, 4'd15, 4'd0);
        begin_battle();
        for (int c = 0; c < 40; c++) begin
            tick();
            if (obs_accepts == 1 && move_ready) break;
        end
        if (MISS_EN) q = {1, 3};
        else q = {1, 2, 3};
        check_seq("miss check", q);
        check("miss turn_cnt", int'(turn_cnt), 1);
        $display("miss check: strobes=%s", seq_str(obs_seq));

        // Reset in the second turn's PL_APPLY.
        set_const(4'd15, 4'd15, 4'd3, 4'd2, 4'd15, 4'd0, 4'd15, 4'd0);
        begin_battle();
        for (int c = 0; c < 40; c++) begin
            tick();
            if (app_ai_dmg && obs_accepts == 2) break;
        end
        check("midreset reached apply", int'(app_ai_dmg), 1);
        check("midreset turn_cnt before", int'(turn_cnt), 1);
        #2 rst = 1'b0;
        #1;
        check("midreset outputs async", out_vec(), 0);
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; move_valid = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        check("midreset idle without start", int'({move_ready, done, turn_cnt}), 0);
        check("midreset no acceptance", obs_accepts, 2);
        start = 1'b1;
        tick();
        check("midreset start resumes", int'(move_ready), 1);
        $display("reset mid-battle: resumed move_ready=%0d", move_ready);

        // Table of complete battles (always-hit accuracy).
        for (int i = 0; i < 8; i++) begin
            set_const(tbl[i].p, tbl[i].a, tbl[i].pd, tbl[i].ad, 4'd15, 4'd0, 4'd15, 4'd0);
            nm = $sformatf("tbl%0d", i);
            begin_battle();
            run_to_end(nm);
            check_common(nm, tbl[i].win, tbl[i].turns, tbl[i].n_load, tbl[i].n_stop);
            check({nm, " load count"}, count_code(1), tbl[i].n_load);
            check({nm, " app_ai count"}, count_code(2), tbl[i].n_aid);
            check({nm, " app_pl count"}, count_code(3), tbl[i].n_pld);
        end

        // Randomized battles against the reference model.
        for (int i = 0; i < 40; i++) begin
            sc_p = 4'($urandom_range(1, 15));
            sc_a = 4'($urandom_range(1, 15));
            for (int t = 0; t < 8; t++) begin
                sc_pd[t]   = 4'($urandom_range(0, 9));
                sc_ad[t]   = 4'($urandom_range(0, 9));
                sc_pacc[t] = 4'($urandom_range(0, 15));
                sc_prng[t] = 4'($urandom_range(0, 15));
                sc_aacc[t] = 4'($urandom_range(0, 15));
                sc_arng[t] = 4'($urandom_range(0, 15));
            end
            model();
            loads = 0;
            foreach (exp_seq[k]) if (exp_seq[k] == 1) loads++;
            nm = $sformatf("rnd%0d", i);
            begin_battle();
            run_to_end(nm);
            check_common(nm, m_win, m_turns, loads, m_stop);
            check_seq(nm, exp_seq);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
